// File: rtl/cv32e40p_ft_fault_supervisor_if.sv
// rtl/cv32e40p_ft_fault_supervisor_if.sv - fault supervisor signal bundle
//
// Purpose: groups the wrapper error inputs, replica force outputs, software
// quarantine request channel, event report stream and status outputs of the
// fault supervisor.
// Modports:
//   slave  - supervisor view (consumes error/broken/request/evt_ready, drives the rest)
//   master - environment view (mirror of slave)
interface cv32e40p_ft_fault_supervisor_if #(
    parameter int N_UNITS = 4,
    parameter int CNT_W   = 16
);
    localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [N_UNITS-1:0]   err_detected_i;
    logic [N_UNITS-1:0]   err_corrected_i;
    logic [3*N_UNITS-1:0] is_broken_i;
    logic [3*N_UNITS-1:0] set_broken_o;
    logic                 clear_i;
    logic                 sw_force_valid_i;
    logic [UW-1:0]        sw_force_unit_i;
    logic [2:0]           sw_force_mask_i;
    logic                 sw_force_ready_o;
    logic                 evt_valid_o;
    logic                 evt_ready_i;
    logic [UW-1:0]        evt_unit_o;
    logic [1:0]           evt_code_o;
    logic [CNT_W-1:0]     total_err_cnt_o;
    logic [CNT_W-1:0]     uncorr_err_cnt_o;
    logic                 fatal_o;
    logic                 force_timeout_o;

    modport slave (
        input  err_detected_i, err_corrected_i, is_broken_i, clear_i,
               sw_force_valid_i, sw_force_unit_i, sw_force_mask_i, evt_ready_i,
        output set_broken_o, sw_force_ready_o, evt_valid_o, evt_unit_o, evt_code_o,
               total_err_cnt_o, uncorr_err_cnt_o, fatal_o, force_timeout_o
    );

    modport master (
        output err_detected_i, err_corrected_i, is_broken_i, clear_i,
               sw_force_valid_i, sw_force_unit_i, sw_force_mask_i, evt_ready_i,
        input  set_broken_o, sw_force_ready_o, evt_valid_o, evt_unit_o, evt_code_o,
               total_err_cnt_o, uncorr_err_cnt_o, fatal_o, force_timeout_o
    );
endinterface

// File: rtl/cv32e40p_ft_fault_supervisor.sv
// rtl/cv32e40p_ft_fault_supervisor.sv - central FT-wrapper fault supervisor
//
// Purpose: collects error/broken status of N_UNITS triplicated wrappers, keeps
// saturating error statistics, raises a sticky fatal flag, serialises fault
// events onto a valid/ready stream and executes software replica quarantines.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave modport of cv32e40p_ft_fault_supervisor_if (error inputs,
//              set_broken outputs, force request channel, event stream, status)
module cv32e40p_ft_fault_supervisor #(
    parameter int N_UNITS         = 4,
    parameter int CNT_W           = 16,
    parameter int CONFIRM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    cv32e40p_ft_fault_supervisor_if.slave  bus
);
    localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int TW = (CONFIRM_TIMEOUT > 0) ? $clog2(CONFIRM_TIMEOUT + 1) : 1;
    localparam int SW = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] CODE_UNCORR = 2'd0;
    localparam logic [1:0] CODE_BROKEN = 2'd1;
    localparam logic [1:0] CODE_FATAL  = 2'd2;
    localparam logic [1:0] CODE_DONE   = 2'd3;

    typedef enum logic {ST_IDLE, ST_CONFIRM} state_e;

    function automatic logic [4:0] popcount_units(input logic [N_UNITS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Registers
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     uncorr_q, uncorr_d;
    logic                 fatal_q, fatal_d;
    logic [N_UNITS-1:0]   fatal_rep_q, fatal_rep_d;
    logic [3*N_UNITS-1:0] brk_prev_q, brk_prev_d;
    logic [N_UNITS-1:0]   pend_uncorr_q, pend_uncorr_d;
    logic [N_UNITS-1:0]   pend_broken_q, pend_broken_d;
    logic [N_UNITS-1:0]   pend_fatal_q, pend_fatal_d;
    logic [N_UNITS-1:0]   pend_done_q, pend_done_d;
    logic                 evt_valid_q, evt_valid_d;
    logic [UW-1:0]        evt_unit_q, evt_unit_d;
    logic [1:0]           evt_code_q, evt_code_d;
    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [UW-1:0]        tgt_unit_q, tgt_unit_d;
    logic [2:0]           tgt_mask_q, tgt_mask_d;
    logic [3*N_UNITS-1:0] quar_q, quar_d;
    logic                 ready_q, ready_d;
    logic                 timeout_q, timeout_d;

    // Combinational helpers
    logic [N_UNITS-1:0] src_uncorr, src_broken, src_fatal, fatal_cond;
    logic [2:0]         tgt_bits;
    logic [SW-1:0]      total_sum, uncorr_sum;
    logic               win_valid;
    logic [1:0]         win_code;
    logic [UW-1:0]      win_unit;
    logic [N_UNITS-1:0] win_bit;
    logic               evt_free, issue;
    logic [N_UNITS-1:0] done_set;

    // Event sources and the broken flags of the unit being confirmed
    always_comb begin
        src_uncorr = bus.err_detected_i & ~bus.err_corrected_i;
        src_broken = '0;
        fatal_cond = '0;
        tgt_bits   = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            src_broken[u] = |(bus.is_broken_i[3*u +: 3] & ~brk_prev_q[3*u +: 3]);
            fatal_cond[u] = popcount3(bus.is_broken_i[3*u +: 3]) >= 2'd2;
            if (tgt_unit_q == UW'(u)) begin
                tgt_bits = bus.is_broken_i[3*u +: 3];
            end
        end
        // FATAL is reported once per unit until clear
        src_fatal = fatal_cond & ~fatal_rep_q;
    end

    // Saturating statistics; the sum is widened so a full popcount cannot wrap
    always_comb begin
        total_sum  = SW'(total_q) + SW'(popcount_units(bus.err_detected_i));
        uncorr_sum = SW'(uncorr_q) + SW'(popcount_units(src_uncorr));
        if (bus.clear_i) begin
            total_d  = '0;
            uncorr_d = '0;
        end else begin
            total_d  = (total_sum > SW'(CNT_MAX)) ? CNT_MAX : total_sum[CNT_W-1:0];
            uncorr_d = (uncorr_sum > SW'(CNT_MAX)) ? CNT_MAX : uncorr_sum[CNT_W-1:0];
        end
        fatal_d     = bus.clear_i ? 1'b0 : (fatal_q | (|fatal_cond));
        fatal_rep_d = bus.clear_i ? '0 : (fatal_rep_q | fatal_cond);
        brk_prev_d  = bus.is_broken_i;
    end

    // Arbitration: scan lowest priority first and units from high to low,
    // so the last hit is the highest-priority code at the lowest unit.
    always_comb begin
        win_valid = 1'b0;
        win_code  = CODE_DONE;
        win_unit  = '0;
        win_bit   = '0;
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if (pend_done_q[u]) begin
                win_valid = 1'b1; win_code = CODE_DONE; win_unit = UW'(u);
            end
        end
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if (pend_broken_q[u]) begin
                win_valid = 1'b1; win_code = CODE_BROKEN; win_unit = UW'(u);
            end
        end
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if (pend_uncorr_q[u]) begin
                win_valid = 1'b1; win_code = CODE_UNCORR; win_unit = UW'(u);
            end
        end
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if (pend_fatal_q[u]) begin
                win_valid = 1'b1; win_code = CODE_FATAL; win_unit = UW'(u);
            end
        end
        for (int u = 0; u < N_UNITS; u++) begin
            win_bit[u] = (win_unit == UW'(u));
        end
        evt_free = ~evt_valid_q | bus.evt_ready_i;
        issue    = evt_free & win_valid & ~bus.clear_i;
    end

    // Pending bits and the event output register. A new occurrence in the
    // issuing cycle re-sets the bit after the issue clears it.
    always_comb begin
        pend_uncorr_d = pend_uncorr_q;
        pend_broken_d = pend_broken_q;
        pend_fatal_d  = pend_fatal_q;
        pend_done_d   = pend_done_q;
        if (issue) begin
            case (win_code)
                CODE_UNCORR: pend_uncorr_d = pend_uncorr_q & ~win_bit;
                CODE_BROKEN: pend_broken_d = pend_broken_q & ~win_bit;
                CODE_FATAL:  pend_fatal_d  = pend_fatal_q & ~win_bit;
                default:     pend_done_d   = pend_done_q & ~win_bit;
            endcase
        end
        pend_uncorr_d = pend_uncorr_d | src_uncorr;
        pend_broken_d = pend_broken_d | src_broken;
        pend_fatal_d  = pend_fatal_d | src_fatal;
        pend_done_d   = pend_done_d | done_set;
        if (bus.clear_i) begin
            pend_uncorr_d = '0;
            pend_broken_d = '0;
            pend_fatal_d  = '0;
            pend_done_d   = '0;
        end

        // Unit/code only change on a load so they stay stable under backpressure
        evt_valid_d = evt_valid_q;
        evt_unit_d  = evt_unit_q;
        evt_code_d  = evt_code_q;
        if (evt_free) begin
            evt_valid_d = issue;
            if (issue) begin
                evt_unit_d = win_unit;
                evt_code_d = win_code;
            end
        end
    end

    // Quarantine FSM
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tgt_unit_d = tgt_unit_q;
        tgt_mask_d = tgt_mask_q;
        quar_d     = quar_q;
        ready_d    = ready_q;
        timeout_d  = timeout_q;
        done_set   = '0;
        case (state_q)
            ST_IDLE: begin
                // Out-of-range units and empty masks are accepted and dropped
                if (bus.sw_force_valid_i && (32'(bus.sw_force_unit_i) < 32'(N_UNITS))
                        && (bus.sw_force_mask_i != 3'b000)) begin
                    for (int u = 0; u < N_UNITS; u++) begin
                        if (bus.sw_force_unit_i == UW'(u)) begin
                            quar_d[3*u +: 3] = quar_q[3*u +: 3] | bus.sw_force_mask_i;
                        end
                    end
                    tgt_unit_d = bus.sw_force_unit_i;
                    tgt_mask_d = bus.sw_force_mask_i;
                    timer_d    = '0;
                    ready_d    = 1'b0;
                    state_d    = ST_CONFIRM;
                end
            end
            default: begin
                // Confirmation takes precedence over a simultaneous timeout
                if ((tgt_bits & tgt_mask_q) == tgt_mask_q) begin
                    for (int u = 0; u < N_UNITS; u++) begin
                        done_set[u] = (tgt_unit_q == UW'(u));
                    end
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if ((32'(timer_q) + 32'd1) >= 32'(CONFIRM_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
        if (bus.clear_i) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            quar_d    = '0;
            ready_d   = 1'b1;
            timeout_d = 1'b0;
            done_set  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q       <= '0;
            uncorr_q      <= '0;
            fatal_q       <= 1'b0;
            fatal_rep_q   <= '0;
            brk_prev_q    <= '0;
            pend_uncorr_q <= '0;
            pend_broken_q <= '0;
            pend_fatal_q  <= '0;
            pend_done_q   <= '0;
            evt_valid_q   <= 1'b0;
            evt_unit_q    <= '0;
            evt_code_q    <= '0;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            tgt_unit_q    <= '0;
            tgt_mask_q    <= '0;
            quar_q        <= '0;
            ready_q       <= 1'b1;
            timeout_q     <= 1'b0;
        end else begin
            total_q       <= total_d;
            uncorr_q      <= uncorr_d;
            fatal_q       <= fatal_d;
            fatal_rep_q   <= fatal_rep_d;
            brk_prev_q    <= brk_prev_d;
            pend_uncorr_q <= pend_uncorr_d;
            pend_broken_q <= pend_broken_d;
            pend_fatal_q  <= pend_fatal_d;
            pend_done_q   <= pend_done_d;
            evt_valid_q   <= evt_valid_d;
            evt_unit_q    <= evt_unit_d;
            evt_code_q    <= evt_code_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            tgt_unit_q    <= tgt_unit_d;
            tgt_mask_q    <= tgt_mask_d;
            quar_q        <= quar_d;
            ready_q       <= ready_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.set_broken_o     = quar_q;
    assign bus.sw_force_ready_o = ready_q;
    assign bus.evt_valid_o      = evt_valid_q;
    assign bus.evt_unit_o       = evt_unit_q;
    assign bus.evt_code_o       = evt_code_q;
    assign bus.total_err_cnt_o  = total_q;
    assign bus.uncorr_err_cnt_o = uncorr_q;
    assign bus.fatal_o          = fatal_q;
    assign bus.force_timeout_o  = timeout_q;
endmodule

// File: tb/tb_cv32e40p_ft_fault_supervisor.sv
// tb/tb_cv32e40p_ft_fault_supervisor.sv - self-checking bench for the fault supervisor
module tb_cv32e40p_ft_fault_supervisor;
    localparam int N  = 4;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   got[$];

    cv32e40p_ft_fault_supervisor_if #(.N_UNITS(N), .CNT_W(CW)) bus ();

    cv32e40p_ft_fault_supervisor #(.N_UNITS(N), .CNT_W(CW), .CONFIRM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] det;
        logic [3:0] cor;
        logic [3:0] exp_total;
        logic [3:0] exp_uncorr;
    } vec_t;

    // Reference model state
    int       m_total, m_uncorr;
    bit       m_fatal, m_valid;
    int       m_unit, m_code;
    bit [11:0] m_prev;
    bit [3:0] m_frep;
    bit       m_pend[4][4];   // [code][unit]

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.err_detected_i   = '0;
        bus.err_corrected_i  = '0;
        bus.is_broken_i      = '0;
        bus.clear_i          = 1'b0;
        bus.sw_force_valid_i = 1'b0;
        bus.sw_force_unit_i  = '0;
        bus.sw_force_mask_i  = '0;
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    // Consume events for n cycles, recording unit*4+code of each handshake
    task automatic collect(input int n);
        got.delete();
        bus.evt_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (bus.evt_valid_o) got.push_back(int'(bus.evt_unit_o) * 4 + int'(bus.evt_code_o));
            @(negedge clk);
        end
    endtask

    task automatic force_req(input logic [1:0] unit, input logic [2:0] mask);
        bus.sw_force_valid_i = 1'b1;
        bus.sw_force_unit_i  = unit;
        bus.sw_force_mask_i  = mask;
        @(negedge clk);
        bus.sw_force_valid_i = 1'b0;
    endtask

    // Count cycles with sw_force_ready_o low; optionally raise is_broken bit at step k
    task automatic count_low(input int confirm_at, input int confirm_bit, output int lowcnt);
        lowcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == confirm_at) bus.is_broken_i[confirm_bit] = 1'b1;
            if (bus.sw_force_ready_o) break;
            lowcnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_total"},  32'(bus.total_err_cnt_o), 0);
        check({tag, "_uncorr"}, 32'(bus.uncorr_err_cnt_o), 0);
        check({tag, "_flags"},  {bus.fatal_o, bus.force_timeout_o, bus.evt_valid_o}, 0);
        check({tag, "_evt"},    {bus.evt_unit_o, bus.evt_code_o}, 0);
        check({tag, "_setbrk"}, 32'(bus.set_broken_o), 0);
        check({tag, "_ready"},  32'(bus.sw_force_ready_o), 1);
    endtask

    task automatic model_reset();
        m_total = 0; m_uncorr = 0; m_fatal = 0; m_valid = 0;
        m_unit = 0; m_code = 0; m_prev = '0; m_frep = '0;
        for (int c = 0; c < 4; c++) for (int u = 0; u < 4; u++) m_pend[c][u] = 0;
    endtask

    // Behaviour of one clock edge given the inputs held before it
    task automatic model_step(input bit [3:0] det, input bit [3:0] cor, input bit [11:0] brk,
                              input bit rdy, input bit clr);
        int  prio[4];
        bit  free, found;
        prio = '{2, 0, 1, 3};
        free = !m_valid || rdy;
        if (clr) begin
            m_total = 0; m_uncorr = 0; m_fatal = 0; m_frep = '0;
            for (int c = 0; c < 4; c++) for (int u = 0; u < 4; u++) m_pend[c][u] = 0;
            if (free) m_valid = 0;
        end else begin
            m_total  = m_total + $countones(det);
            m_uncorr = m_uncorr + $countones(det & ~cor);
            if (m_total > 15)  m_total = 15;
            if (m_uncorr > 15) m_uncorr = 15;
            if (free) begin
                found = 0;
                for (int p = 0; p < 4; p++)
                    for (int u = 0; u < 4; u++)
                        if (!found && m_pend[prio[p]][u]) begin
                            found = 1; m_unit = u; m_code = prio[p];
                            m_pend[prio[p]][u] = 0;
                        end
                m_valid = found;
            end
            for (int u = 0; u < 4; u++) begin
                if (det[u] && !cor[u]) m_pend[0][u] = 1;
                if ((brk[3*u +: 3] & ~m_prev[3*u +: 3]) != 0) m_pend[1][u] = 1;
                if ($countones(brk[3*u +: 3]) >= 2) begin
                    m_fatal = 1;
                    if (!m_frep[u]) begin m_pend[2][u] = 1; m_frep[u] = 1; end
                end
            end
        end
        m_prev = brk;
    endtask

    initial begin
        vec_t vecs[6];
        int   lowcnt;
        int   exp_ev[3];
        bit   seen;
        logic [31:0] act, exp;

        vecs[0] = '{4'b0100, 4'b0100, 4'd1, 4'd0};
        vecs[1] = '{4'b1111, 4'b0000, 4'd4, 4'd4};
        vecs[2] = '{4'b1010, 4'b1000, 4'd2, 4'd1};
        vecs[3] = '{4'b0000, 4'b1111, 4'd0, 4'd0};
        vecs[4] = '{4'b0011, 4'b0001, 4'd2, 4'd1};
        vecs[5] = '{4'b1111, 4'b1111, 4'd4, 4'd0};

        idle_inputs();
        bus.evt_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_in");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_out");

        // Corrected errors only: counted, no event
        bus.evt_ready_i = 1'b1;
        bus.err_detected_i = 4'b0100; bus.err_corrected_i = 4'b0100;
        repeat (3) @(negedge clk);
        bus.err_detected_i = '0; bus.err_corrected_i = '0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.evt_valid_o) seen = 1;
            @(negedge clk);
        end
        check("corr_total", 32'(bus.total_err_cnt_o), 3);
        check("corr_uncorr", 32'(bus.uncorr_err_cnt_o), 0);
        check("corr_no_evt", 32'(seen), 0);

        // Table: single cycle of errors after a clear
        foreach (vecs[i]) begin
            do_clear();
            bus.err_detected_i = vecs[i].det; bus.err_corrected_i = vecs[i].cor;
            @(negedge clk);
            bus.err_detected_i = '0; bus.err_corrected_i = '0;
            check($sformatf("vec%0d_total", i), 32'(bus.total_err_cnt_o), 32'(vecs[i].exp_total));
            check($sformatf("vec%0d_uncorr", i), 32'(bus.uncorr_err_cnt_o), 32'(vecs[i].exp_uncorr));
        end
        repeat (6) @(negedge clk);
        do_clear();

        // Saturation and backpressure
        bus.evt_ready_i = 1'b0;
        bus.err_detected_i = 4'b0011; bus.err_corrected_i = 4'b0000;
        repeat (8) @(negedge clk);
        bus.err_detected_i = '0;
        check("sat_total", 32'(bus.total_err_cnt_o), 15);
        check("sat_uncorr", 32'(bus.uncorr_err_cnt_o), 15);
        check("hold_first", {bus.evt_valid_o, bus.evt_unit_o, bus.evt_code_o}, {1'b1, 2'd0, 2'd0});
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({bus.evt_valid_o, bus.evt_unit_o, bus.evt_code_o} !== {1'b1, 2'd0, 2'd0}) seen = 1;
        end
        check("hold_stable", 32'(seen), 0);
        collect(10);
        exp_ev = '{0, 0, 4};
        check("sat_nevt", got.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("sat_evt%0d", i), (i < got.size()) ? got[i] : -1, exp_ev[i]);
        do_clear();

        // Broken escalation on unit 3
        bus.is_broken_i[11:9] = 3'b001;
        @(negedge clk);
        bus.is_broken_i[11:9] = 3'b011;
        collect(8);
        exp_ev = '{13, 14, 13};
        check("brk_nevt", got.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("brk_evt%0d", i), (i < got.size()) ? got[i] : -1, exp_ev[i]);
        check("fatal_set", 32'(bus.fatal_o), 1);
        bus.is_broken_i = '0;
        repeat (3) @(negedge clk);
        check("fatal_sticky", 32'(bus.fatal_o), 1);
        do_clear();
        check("fatal_clr", 32'(bus.fatal_o), 0);

        // Quarantine of unit 1 replica 2, confirmed four cycles later
        force_req(2'd1, 3'b100);
        check("frc_setbrk", 32'(bus.set_broken_o), 32'h020);
        count_low(5, 5, lowcnt);
        check("frc_low_cycles", lowcnt, 5);
        collect(8);
        check("frc_nevt", got.size(), 2);
        check("frc_evt0", (got.size() > 0) ? got[0] : -1, 5);
        check("frc_evt1", (got.size() > 1) ? got[1] : -1, 7);

        // Empty mask is accepted and dropped
        force_req(2'd2, 3'b000);
        check("drop_ready", 32'(bus.sw_force_ready_o), 1);
        check("drop_setbrk", 32'(bus.set_broken_o), 32'h020);
        collect(4);
        check("drop_nevt", got.size(), 0);

        // Unconfirmed quarantine times out
        bus.is_broken_i = '0;
        @(negedge clk);
        force_req(2'd0, 3'b011);
        count_low(0, 0, lowcnt);
        check("to_low_cycles", lowcnt, 15);
        check("to_flag", 32'(bus.force_timeout_o), 1);
        check("to_setbrk", 32'(bus.set_broken_o), 32'h023);
        repeat (4) @(negedge clk);
        do_clear();
        check("clr_setbrk", 32'(bus.set_broken_o), 0);
        check("clr_cnt", {bus.total_err_cnt_o, bus.uncorr_err_cnt_o}, 0);
        check("clr_flags", {bus.fatal_o, bus.force_timeout_o}, 0);
        repeat (6) @(negedge clk);

        // Asynchronous reset while confirming with a held event
        bus.evt_ready_i = 1'b0;
        force_req(2'd2, 3'b001);
        bus.err_detected_i = 4'b0001;
        @(negedge clk);
        bus.err_detected_i = '0;
        repeat (2) @(negedge clk);
        check("pre_rst", {bus.evt_valid_o, bus.sw_force_ready_o}, 2'b10);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomised run against the reference model
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit [3:0]  det, cor;
            bit [11:0] brk;
            bit        rdy, clr;
            act = {5'd0, bus.set_broken_o, bus.force_timeout_o, bus.total_err_cnt_o,
                   bus.uncorr_err_cnt_o, bus.fatal_o, bus.evt_valid_o,
                   bus.evt_valid_o ? bus.evt_unit_o : 2'd0,
                   bus.evt_valid_o ? bus.evt_code_o : 2'd0};
            exp = {5'd0, 12'd0, 1'b0, 4'(m_total), 4'(m_uncorr), m_fatal, m_valid,
                   m_valid ? 2'(m_unit) : 2'd0, m_valid ? 2'(m_code) : 2'd0};
            check($sformatf("rand_c%0d", cyc), act, exp);
            det = 4'($urandom & $urandom);
            cor = 4'($urandom);
            brk = bus.is_broken_i;
            if ($urandom_range(0, 7) == 0) begin
                int u;
                u = $urandom_range(0, 3);
                brk[3*u +: 3] = 3'($urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            bus.err_detected_i  = det;
            bus.err_corrected_i = cor;
            bus.is_broken_i     = brk;
            bus.evt_ready_i     = rdy;
            bus.clear_i         = clr;
            model_step(det, cor, brk, rdy, clr);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
